// File: rtl/lfsr_noise_bank.sv
// Bank of NCH Fibonacci noise LFSRs served round-robin into one tagged valid/ready stream.
// Optional zero-state recovery is enabled by defining LFSR_NOISE_LOCKUP_RECOVER_EN.
module lfsr_noise_bank #(
  parameter int                NCH     = 4,
  parameter int                LFSR_W  = 17,
  parameter int                OUT_W   = 32,
  parameter logic [LFSR_W-1:0] POLY    = 17'h12000,
  parameter logic [LFSR_W-1:0] RST_VAL = 17'h10001,
  parameter int                CH_W    = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    ch_en,
  input  logic              prog_valid,
  input  logic [CH_W-1:0]   prog_ch,
  input  logic [LFSR_W-1:0] prog_seed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [NCH-1:0]    lockup
);

  logic [LFSR_W-1:0] state_reg [NCH];
  logic [CH_W-1:0]   rr_ptr_reg;
  logic              out_valid_reg;
  logic [OUT_W-1:0]  out_data_reg;
  logic [CH_W-1:0]   out_ch_reg;

  logic [NCH-1:0]    prog_hit;
  logic [NCH-1:0]    elig;
  logic              hi_found;
  logic [CH_W-1:0]   hi_ch;
  logic [CH_W-1:0]   lo_ch;
  logic              cand_found;
  logic [CH_W-1:0]   cand_ch;
  logic [CH_W-1:0]   cand_succ;
  logic [LFSR_W-1:0] cand_state;
  logic [LFSR_W-1:0] cand_next;
  logic [OUT_W-1:0]  cand_word;
  logic [LFSR_W-1:0] step;
  logic              fb;
  logic              can_load;
  logic              fire;
  logic              recover;
  logic              issue;

  // A channel being reseeded this cycle is not eligible; out-of-range prog_ch matches nothing.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
    assign prog_hit[gi] = prog_valid && (prog_ch == CH_W'(gi));
    assign elig[gi]     = ch_en[gi] && !prog_hit[gi];
  end

  // Lowest eligible channel at/after rr_ptr, else lowest eligible overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (elig[c]) begin
        lo_ch = CH_W'(c);
        if (CH_W'(c) >= rr_ptr_reg) begin
          hi_found = 1'b1;
          hi_ch    = CH_W'(c);
        end
      end
    end
  end

  assign cand_found = |elig;
  assign cand_ch    = hi_found ? hi_ch : lo_ch;
  assign cand_succ  = (cand_ch == CH_W'(NCH - 1)) ? '0 : cand_ch + 1'b1;
  assign cand_state = state_reg[cand_ch];

  // Single unrolled OUT_W-step datapath shared by all channels via the candidate mux.
  always_comb begin
    step      = cand_state;
    cand_word = '0;
    fb        = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      fb           = ^(step & POLY);
      cand_word[i] = fb;
      step         = {step[LFSR_W-2:0], fb};
    end
    cand_next = step;
  end

  assign can_load = !out_valid_reg || out_ready;
  assign fire     = en && can_load && cand_found;

`ifdef LFSR_NOISE_LOCKUP_RECOVER_EN
  assign recover = fire && (cand_state == '0);
`else
  assign recover = 1'b0;
`endif

  assign issue = fire && !recover;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        state_reg[c] <= RST_VAL ^ LFSR_W'(c);
      end
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (prog_hit[c]) begin
          state_reg[c] <= prog_seed;
        end else if (fire && (cand_ch == CH_W'(c))) begin
          state_reg[c] <= recover ? (RST_VAL ^ LFSR_W'(c)) : cand_next;
        end
      end
      if (fire) begin
        rr_ptr_reg <= cand_succ;
      end
      if (issue) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= cand_word;
        out_ch_reg    <= cand_ch;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef LFSR_NOISE_LOCKUP_RECOVER_EN
  logic [NCH-1:0] lockup_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockup_reg <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (prog_hit[c]) begin
          lockup_reg[c] <= 1'b0;
        end else if (recover && (cand_ch == CH_W'(c))) begin
          lockup_reg[c] <= 1'b1;
        end
      end
    end
  end

  assign lockup = lockup_reg;
`else
  assign lockup = '0;
`endif

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_lfsr_noise_bank.sv
// Directed bench for lfsr_noise_bank: vector table plus hand sequences for lockup and async reset.
module tb_lfsr_noise_bank;

  localparam logic [16:0] RV = 17'h10001;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  ch_en;
  logic        prog_valid;
  logic [1:0]  prog_ch;
  logic [16:0] prog_seed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic [3:0]  lockup;

  lfsr_noise_bank dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_en      (ch_en),
    .prog_valid (prog_valid),
    .prog_ch    (prog_ch),
    .prog_seed  (prog_seed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .lockup     (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [16:0] model [4];
  logic [31:0] held_data;

  typedef struct {
    logic        en;
    logic [3:0]  ch_en;
    logic        pv;
    logic [1:0]  pch;
    logic [16:0] seed;
    logic        rdy;
    logic        ev;
    logic [1:0]  ech;
    logic        hold;
    logic        dchk;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: x^17+x^14+1, feedback from bits 16 and 13.
  function automatic void lfsr_ref(input logic [16:0] s, output logic [31:0] w, output logic [16:0] n);
    logic [16:0] t;
    logic        b;
    t = s;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      b    = t[16] ^ t[13];
      w[i] = b;
      t    = {t[15:0], b};
    end
    n = t;
  endfunction

  task automatic reset_model();
    for (int c = 0; c < 4; c++) model[c] = RV ^ 17'(c);
  endtask

  // Scoreboard the handshake that completes at the coming edge, then advance one cycle.
  task automatic cycle();
    logic [31:0] w;
    logic [16:0] n;
    if (out_valid && out_ready) begin
      lfsr_ref(model[out_ch], w, n);
      $display("word ch=%0d data=%08h ref=%08h", out_ch, out_data, w);
      chk("seq_word", 64'(out_data), 64'(w));
      model[out_ch] = n;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [16:0] n;

    tbl[0]  = '{1'b1, 4'b0001, 1'b1, 2'd0, 17'h00001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 32'h08012000};
    tbl[2]  = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 4'b0101, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 4'b0011, 1'b1, 2'd1, 17'h1ACE5, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 4'b0011, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[17] = '{1'b1, 4'b0011, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[18] = '{1'b1, 4'b0000, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
    tbl[19] = '{1'b1, 4'b0010, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[20] = '{1'b0, 4'b0011, 1'b0, 2'd0, 17'h00000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 32'h0};
    tbl[21] = '{1'b0, 4'b0011, 1'b0, 2'd0, 17'h00000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};

    rst        = 1'b1;
    en         = 1'b0;
    ch_en      = 4'b0000;
    prog_valid = 1'b0;
    prog_ch    = 2'd0;
    prog_seed  = 17'h0;
    out_ready  = 1'b0;
    held_data  = 32'h0;
    reset_model();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_data",  64'(out_data),  64'(32'h0));
    chk("rst_ch",    64'(out_ch),    64'(2'd0));
    chk("rst_lockup", 64'(lockup),   64'(4'b0000));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      en         = tbl[i].en;
      ch_en      = tbl[i].ch_en;
      prog_valid = tbl[i].pv;
      prog_ch    = tbl[i].pch;
      prog_seed  = tbl[i].seed;
      out_ready  = tbl[i].rdy;
      if (tbl[i].pv) model[tbl[i].pch] = tbl[i].seed;
      cycle();
      chk($sformatf("row%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("row%0d_ch", i), 64'(out_ch), 64'(tbl[i].ech));
      if (tbl[i].hold) chk($sformatf("row%0d_hold", i), 64'(out_data), 64'(held_data));
      if (tbl[i].dchk) chk($sformatf("row%0d_data", i), 64'(out_data), 64'(tbl[i].edata));
      held_data = out_data;
    end

    // Zero seed on channel 2.
    en = 1'b1; ch_en = 4'b0100; out_ready = 1'b1;
    prog_valid = 1'b1; prog_ch = 2'd2; prog_seed = 17'h0;
    model[2] = 17'h0;
    cycle();
    chk("z_prog_valid", 64'(out_valid), 64'(1'b0));
    chk("z_prog_lockup", 64'(lockup), 64'(4'b0000));
    prog_valid = 1'b0;
    cycle();
`ifdef LFSR_NOISE_LOCKUP_RECOVER_EN
    chk("z_skip_valid", 64'(out_valid), 64'(1'b0));
    chk("z_lockup", 64'(lockup), 64'(4'b0100));
    model[2] = RV ^ 17'd2;
`else
    chk("z_word_valid", 64'(out_valid), 64'(1'b1));
    chk("z_word_data", 64'(out_data), 64'(32'h0));
    chk("z_lockup_tied", 64'(lockup), 64'(4'b0000));
`endif
    cycle();
    chk("z_next_valid", 64'(out_valid), 64'(1'b1));
    chk("z_next_ch", 64'(out_ch), 64'(2'd2));
`ifdef LFSR_NOISE_LOCKUP_RECOVER_EN
    lfsr_ref(RV ^ 17'd2, w, n);
    chk("z_recovered_data", 64'(out_data), 64'(w));
`else
    chk("z_again_data", 64'(out_data), 64'(32'h0));
`endif
    ch_en = 4'b0000;
    cycle();
    chk("z_drain_valid", 64'(out_valid), 64'(1'b0));
    prog_valid = 1'b1; prog_ch = 2'd2; prog_seed = 17'h00ABC;
    model[2] = 17'h00ABC;
    cycle();
    prog_valid = 1'b0;
    chk("z_lockup_clear", 64'(lockup), 64'(4'b0000));

    // Async reset while a word is pending.
    ch_en = 4'b0001; out_ready = 1'b0;
    cycle();
    chk("r_pending_valid", 64'(out_valid), 64'(1'b1));
    chk("r_pending_ch", 64'(out_ch), 64'(2'd0));
    #2;
    rst = 1'b1;
    #1;
    chk("r_async_valid", 64'(out_valid), 64'(1'b0));
    chk("r_async_data", 64'(out_data), 64'(32'h0));
    chk("r_async_lockup", 64'(lockup), 64'(4'b0000));
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    out_ready = 1'b1;
    cycle();
    lfsr_ref(RV, w, n);
    chk("r_first_valid", 64'(out_valid), 64'(1'b1));
    chk("r_first_ch", 64'(out_ch), 64'(2'd0));
    chk("r_first_data", 64'(out_data), 64'(w));
    ch_en = 4'b0000;
    cycle();
    chk("r_drain_valid", 64'(out_valid), 64'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
